// File: rtl/sprite_line_fetcher.sv
// Purpose : sprite attribute table plus per-scanline scan/fetch engine feeding the line buffer.
// Latency : ROM address to line-buffer write is 1 cycle; a worst-case line fill is 341 cycles.
// Backpr. : none; a line start while busy sets sticky overrun and restarts. SPRITE_SHADOW_EN adds a frame-synchronous shadow table.
`timescale 1ns/1ps
module sprite_line_fetcher #(
    parameter int NUM_SPRITES = 20,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  VGA_HCOUNT,
    input  logic [9:0]  VGA_VCOUNT,
    input  logic        tbl_we,
    input  logic [4:0]  tbl_addr,
    input  logic [23:0] tbl_data,
    output logic [12:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        lb_we,
    output logic [9:0]  lb_addr,
    output logic [23:0] lb_data,
    output logic        line_done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [9:0]  tgt_q, tgt_d;
    logic [9:0]  x_q, x_d;
    logic [4:0]  type_q, type_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic        overrun_q, overrun_d;
    logic [10:0] pcol_q;
    logic        pvld_q;
    logic [23:0] tbl_q [NUM_SPRITES];
`ifdef SPRITE_SHADOW_EN
    logic [23:0] shad_q [NUM_SPRITES];
`endif

    logic        line_start;
    logic [9:0]  tgt_next;
    logic [23:0] cur_ent;
    logic [9:0]  cur_y;
    logic [9:0]  diff;
    logic        hit;

    assign line_start = (VGA_HCOUNT == 10'd0);
    assign tgt_next   = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0 : VGA_VCOUNT + 10'd1;
    assign cur_ent    = tbl_q[idx_q];
    assign cur_y      = {1'b0, cur_ent[13:5]};
    assign diff       = tgt_q - cur_y;
    assign hit        = (cur_ent[4:0] != 5'd0) && (tgt_q >= cur_y) && (diff < 10'd16);

    // Attribute table storage; SCAN reads the pre-write value when both hit the same entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                tbl_q[i] <= '0;
`ifdef SPRITE_SHADOW_EN
                shad_q[i] <= '0;
`endif
            end
        end else begin
`ifdef SPRITE_SHADOW_EN
            if (line_start && (VGA_VCOUNT == 10'(V_ACTIVE)))
                tbl_q <= shad_q;
            if (tbl_we && (tbl_addr < 5'(NUM_SPRITES)))
                shad_q[tbl_addr] <= tbl_data;
`else
            if (tbl_we && (tbl_addr < 5'(NUM_SPRITES)))
                tbl_q[tbl_addr] <= tbl_data;
`endif
        end
    end

    // Fill engine state and the one-stage column pipeline that tracks the ROM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tgt_q     <= '0;
            x_q       <= '0;
            type_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            pcol_q    <= '0;
            pvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tgt_q     <= tgt_d;
            x_q       <= x_d;
            type_q    <= type_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            pcol_q    <= {1'b0, x_q} + {7'b0, col_q};
            pvld_q    <= (state_q == FETCH);
        end
    end

    // Next-state: line start always (re)starts from the top entry; otherwise scan high-to-low index.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tgt_d     = tgt_q;
        x_d       = x_q;
        type_d    = type_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        if (line_start) begin
            tgt_d   = tgt_next;
            idx_d   = 5'(NUM_SPRITES - 1);
            state_d = SCAN;
            if (state_q != IDLE)
                overrun_d = 1'b1;
        end else begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        x_d     = cur_ent[23:14];
                        type_d  = cur_ent[4:0];
                        row_d   = diff[3:0];
                        col_d   = 4'd0;
                        state_d = FETCH;
                    end else if (idx_q == 5'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 5'd1;
                    end
                end
                FETCH: begin
                    col_d = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        if (idx_q == 5'd0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q - 5'd1;
                            state_d = SCAN;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign rom_addr  = {type_q, row_q, col_q};
    assign lb_we     = pvld_q && (rom_data != 24'h0) && (pcol_q < 11'(H_ACTIVE));
    assign lb_addr   = lb_we ? pcol_q[9:0] : 10'd0;
    assign lb_data   = lb_we ? rom_data : 24'h0;
    assign line_done = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
`timescale 1ns/1ps
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  VGA_HCOUNT, VGA_VCOUNT;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic [12:0] rom_addr;
    logic [23:0] rom_data = 24'h0;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [23:0] lb_data;
    logic        line_done;
    logic        overrun;

    always #5 clk = ~clk;

    sprite_line_fetcher dut (
        .clk(clk), .reset(reset), .VGA_HCOUNT(VGA_HCOUNT), .VGA_VCOUNT(VGA_VCOUNT),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .line_done(line_done), .overrun(overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sprite ROM: types 6 and 7 are transparent at column 4, all else opaque.
    function automatic logic [23:0] rom_fn(input logic [12:0] a);
        if ((a[12:8] == 5'd6 || a[12:8] == 5'd7) && a[3:0] == 4'd4)
            return 24'h0;
        return {8'h5A, 3'b000, a};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Reference attribute table (active plus shadow copy).
    int m_x[20], m_y[20], m_t[20];
    int s_x[20], s_y[20], s_t[20];

    typedef struct packed {
        logic [9:0]  addr;
        logic [23:0] dat;
    } wr_t;
    wr_t sb_q[$];
    bit  sb_en = 1'b0;

    // Scoreboard consumer: every line-buffer write must match the next expected one.
    always @(negedge clk) begin
        if (sb_en && lb_we === 1'b1) begin
            wr_t e;
            if (sb_q.size() == 0) begin
                check_val("wr_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("wr_addr", {22'b0, lb_addr}, {22'b0, e.addr});
                check_val("wr_data", {8'b0, lb_data}, {8'b0, e.dat});
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 20; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_t[i] = 0;
            s_x[i] = 0; s_y[i] = 0; s_t[i] = 0;
        end
    endtask

    task automatic tbl_write(input int idx, input int x, input int y, input int t);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_addr = 5'(idx);
        tbl_data = {10'(x), 9'(y), 5'(t)};
        @(negedge clk);
        tbl_we   = 1'b0;
        if (idx < 20) begin
`ifdef SPRITE_SHADOW_EN
            s_x[idx] = x; s_y[idx] = y; s_t[idx] = t;
`else
            m_x[idx] = x; m_y[idx] = y; m_t[idx] = t;
`endif
        end
    endtask

    // Push the expected writes for the line after vc and return the expected fill latency.
    task automatic build_exp(input int vc, output int lat);
        int t;
        t   = (vc == 524) ? 0 : vc + 1;
        lat = 1;
        for (int i = 19; i >= 0; i--) begin
            lat++;
            if (m_t[i] != 0 && t >= m_y[i] && (t - m_y[i]) < 16) begin
                lat += 16;
                for (int c = 0; c < 16; c++) begin
                    logic [12:0] a;
                    wr_t w;
                    a = {5'(m_t[i]), 4'(t - m_y[i]), 4'(c)};
                    if (rom_fn(a) != 24'h0 && (m_x[i] + c) < 640) begin
                        w.addr = 10'(m_x[i] + c);
                        w.dat  = rom_fn(a);
                        sb_q.push_back(w);
                    end
                end
            end
        end
    endtask

    // One-cycle line start; returns at the falling edge of fill cycle 1.
    task automatic pulse_line(input int vc);
        @(negedge clk);
        #1;
        VGA_VCOUNT = 10'(vc);
        VGA_HCOUNT = 10'd0;
        @(negedge clk);
        VGA_HCOUNT = 10'd1;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int cyc;
        cyc = 1;
        while (line_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_val(tag, 32'(cyc), 32'(exp_lat));
        @(negedge clk);
        check_val("done_pulse", {31'b0, line_done}, 32'd0);
        check_val("wr_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic run_line(input string tag, input int vc);
        int lat;
`ifdef SPRITE_SHADOW_EN
        if (vc == 480) begin
            for (int i = 0; i < 20; i++) begin
                m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_t[i] = s_t[i];
            end
        end
`endif
        build_exp(vc, lat);
        pulse_line(vc);
        wait_done(tag, lat);
    endtask

    // Make staged table writes visible when writes go through the shadow table.
    task automatic commit();
`ifdef SPRITE_SHADOW_EN
        run_line("lat_commit", 480);
`endif
    endtask

    initial begin
        int lat;
        reset      = 1'b0;
        VGA_HCOUNT = 10'd1;
        VGA_VCOUNT = 10'd0;
        tbl_we     = 1'b0;
        tbl_addr   = 5'd0;
        tbl_data   = 24'h0;
        clear_model();
        repeat (3) @(negedge clk);
        check_val("rst_lb_we", {31'b0, lb_we}, 32'd0);
        check_val("rst_done", {31'b0, line_done}, 32'd0);
        check_val("rst_overrun", {31'b0, overrun}, 32'd0);
        check_val("rst_rom_addr", {19'b0, rom_addr}, 32'd0);
        check_val("rst_lb_addr", {22'b0, lb_addr}, 32'd0);
        check_val("rst_lb_data", {8'b0, lb_data}, 32'd0);
        reset = 1'b1;
        sb_en = 1'b1;

        run_line("lat_empty", 10);

        tbl_write(0, 100, 50, 3);
        commit();
        run_line("lat_e0", 49);
        run_line("lat_row15", 64);
        run_line("lat_miss16", 65);
        run_line("lat_miss_above", 48);

        tbl_write(21, 0, 200, 9);
        commit();
        run_line("lat_badaddr", 199);

        tbl_write(0, 630, 50, 3);
        commit();
        run_line("lat_edge", 49);

        tbl_write(0, 200, 50, 7);
        tbl_write(5, 200, 50, 6);
        commit();
        run_line("lat_overlap", 52);

        tbl_write(0, 10, 0, 2);
        tbl_write(5, 0, 0, 0);
        commit();
        run_line("lat_wrap", 524);
        run_line("lat_wrap_miss", 523);

        for (int i = 0; i < 20; i++) tbl_write(i, i * 31, 300, i + 1);
        commit();
        run_line("lat_all", 299);
        check_val("overrun_idle", {31'b0, overrun}, 32'd0);

        // Second line start 100 cycles into a full-length fill.
        build_exp(299, lat);
        pulse_line(299);
        repeat (99) @(negedge clk);
        #1;
        sb_en = 1'b0;
        sb_q.delete();
        VGA_VCOUNT = 10'd305;
        VGA_HCOUNT = 10'd0;
        @(negedge clk);
        VGA_HCOUNT = 10'd1;
        check_val("overrun_set", {31'b0, overrun}, 32'd1);
        #1;
        build_exp(305, lat);
        sb_en = 1'b1;
        wait_done("lat_restart", lat - 0);
        check_val("overrun_sticky", {31'b0, overrun}, 32'd1);

        // Reset while fetching entry 19.
        build_exp(299, lat);
        pulse_line(299);
        repeat (4) @(negedge clk);
        check_val("we_pre_rst", {31'b0, lb_we}, 32'd1);
        #1;
        sb_en = 1'b0;
        reset = 1'b0;
        #1;
        check_val("rst_mid_we", {31'b0, lb_we}, 32'd0);
        check_val("rst_mid_done", {31'b0, line_done}, 32'd0);
        check_val("rst_mid_ovr", {31'b0, overrun}, 32'd0);
        check_val("rst_mid_rom", {19'b0, rom_addr}, 32'd0);
        sb_q.delete();
        clear_model();
        repeat (2) @(negedge clk);
        check_val("rst_hold_we", {31'b0, lb_we}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        sb_en = 1'b1;
        run_line("lat_post_rst", 299);
        check_val("overrun_post_rst", {31'b0, overrun}, 32'd0);

`ifdef SPRITE_SHADOW_EN
        VGA_VCOUNT = 10'd100;
        tbl_write(2, 50, 105, 4);
        run_line("sh_before", 109);
        run_line("sh_copy", 480);
        run_line("sh_after", 109);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
